// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - two-port (fetch/data) sequencer onto one shared 256x8 RAM
// Optional round-robin arbitration on contention: `define SHARED_MEM_ARB_RR_EN
module shared_mem_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        busy,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;  // 1 = data port owns the current access
  logic              ram_rw_q, ram_rw_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [31:0]       ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant_d;

`ifdef SHARED_MEM_ARB_RR_EN
  logic              last_owner_q, last_owner_d;

  assign grant_d = d_req & (~i_req | ~last_owner_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_size_q <= 2'b10;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef SHARED_MEM_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ram_rw_q   <= ram_rw_d;
      ram_size_q <= ram_size_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef SHARED_MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ram_rw_d   = ram_rw_q;
    ram_size_d = ram_size_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef SHARED_MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          owner_d = grant_d;
`ifdef SHARED_MEM_ARB_RR_EN
          last_owner_d = grant_d;
`endif
          if (grant_d) begin
            ram_rw_d   = d_rw;
            ram_size_d = (d_size == 2'b11) ? 2'b10 : d_size;
            ram_addr_d = d_addr;
            ram_din_d  = d_wdata;
          end else begin
            ram_rw_d   = 1'b0;
            ram_size_d = 2'b10;
            ram_addr_d = i_addr;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          // Writes leave the requester's read data untouched.
          if (!ram_rw_q) begin
            if (owner_q) d_rdata_d = ram_dout;
            else         i_rdata_d = ram_dout;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_enable = (state_q == S_ACCESS);
    i_ack      = (state_q == S_DONE) & ~owner_q;
    d_ack      = (state_q == S_DONE) &  owner_q;
    busy       = (state_q != S_IDLE);
    if_stall   = i_req & ~i_ack;
    mem_stall  = d_req & ~d_ack;
    ram_rw     = ram_rw_q;
    ram_size   = ram_size_q;
    ram_addr   = ram_addr_q;
    ram_din    = ram_din_q;
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - randomized check of shared_mem_arbiter against a transaction-level schedule model
module tb_shared_mem_arbiter;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rw;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        i_ack, d_ack, if_stall, mem_stall, busy;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_enable, ram_rw;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr, ram_din, ram_dout;

  logic [7:0]  ram_mem [256];
  logic [7:0]  ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.ACCESS_CYCLES(AC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall), .busy(busy),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_size(ram_size),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] rd_bytes(input logic [7:0] b0, b1, b2, b3, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, b0};
      2'b01:   return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Little-endian byte RAM seen by the DUT.
  always_comb begin
    ram_dout = rd_bytes(ram_mem[ram_addr[7:0]], ram_mem[8'(ram_addr[7:0] + 8'd1)],
                        ram_mem[8'(ram_addr[7:0] + 8'd2)], ram_mem[8'(ram_addr[7:0] + 8'd3)], ram_size);
  end

  always @(posedge clk) begin
    if (ram_enable && ram_rw) begin
      ram_mem[ram_addr[7:0]] = ram_din[7:0];
      if (ram_size != 2'b00) ram_mem[8'(ram_addr[7:0] + 8'd1)] = ram_din[15:8];
      if (ram_size[1]) begin
        ram_mem[8'(ram_addr[7:0] + 8'd2)] = ram_din[23:16];
        ram_mem[8'(ram_addr[7:0] + 8'd3)] = ram_din[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Schedule model state: cycles at which the current grant's phases occur.
  int          cyc, idle_at, acc_lo, acc_hi, ack_at;
  bit          own_d, ip, dp, pend_rd, exp_en, exp_iack, exp_dack;
  logic [31:0] e_addr, e_din, e_irdata, e_drdata, pend_rdata;
  logic        e_rw;
  logic [1:0]  e_size;
  logic [7:0]  a;

  initial begin
    for (int k = 0; k < 256; k++) ram_mem[k] = 8'($urandom);
    ram_mem[8'h10] = 8'h05; ram_mem[8'h11] = 8'h10;
    ram_mem[8'h12] = 8'hA0; ram_mem[8'h13] = 8'hE3;
    reset = 1'b1; i_req = 0; d_req = 0; d_rw = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_i_ack", i_ack, 0);        chk("rst_d_ack", d_ack, 0);
    chk("rst_ram_enable", ram_enable, 0); chk("rst_ram_rw", ram_rw, 0);
    chk("rst_busy", busy, 0);          chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);    chk("rst_ram_size", ram_size, 2'b10);

    // Single fetch from 0x10.
    tick();
    i_req = 1; i_addr = 32'h10; #1;
    chk("t1_stall_T", if_stall, 1); chk("t1_en_T", ram_enable, 0);
    for (int k = 1; k <= AC; k++) begin
      tick(); #1;
      chk("t1_en_acc", ram_enable, 1); chk("t1_addr", ram_addr, 32'h10);
      chk("t1_rw", ram_rw, 0);         chk("t1_stall_acc", if_stall, 1);
    end
    tick(); #1;
    chk("t1_ack", i_ack, 1); chk("t1_rdata", i_rdata, 32'hE3A01005);
    chk("t1_en_done", ram_enable, 0); chk("t1_stall_done", if_stall, 0);
    tick(); i_req = 0; #1;
    chk("t1_ack_gone", i_ack, 0); chk("t1_idle", busy, 0);

    // Randomized traffic against the schedule model.
    for (int k = 0; k < 256; k++) ref_mem[k] = ram_mem[k];
    cyc = 0; idle_at = 0; acc_lo = 1; acc_hi = 0; ack_at = -1; own_d = 0;
    ip = 0; dp = 0; pend_rd = 0; e_irdata = 32'hE3A01005; e_drdata = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(0, 3) == 0) begin ip = 1; i_addr = $urandom; end
      if (!dp && $urandom_range(0, 3) == 0) begin
        dp = 1; d_addr = $urandom; d_rw = 1'($urandom_range(0, 1));
        d_size = 2'($urandom_range(0, 3)); d_wdata = $urandom;
      end
      i_req = ip; d_req = dp;
      #1;
      if (cyc == ack_at && pend_rd) begin
        if (own_d) e_drdata = pend_rdata; else e_irdata = pend_rdata;
      end
      exp_en   = (cyc >= acc_lo) && (cyc <= acc_hi);
      exp_iack = (cyc == ack_at) && !own_d;
      exp_dack = (cyc == ack_at) && own_d;
      chk("ram_enable", ram_enable, exp_en);
      if (exp_en) begin
        chk("ram_addr", ram_addr, e_addr); chk("ram_rw", ram_rw, e_rw);
        chk("ram_size", ram_size, e_size);
        if (e_rw) chk("ram_din", ram_din, e_din);
      end
      chk("i_ack", i_ack, exp_iack);     chk("d_ack", d_ack, exp_dack);
      chk("if_stall", if_stall, ip && !exp_iack);
      chk("mem_stall", mem_stall, dp && !exp_dack);
      chk("busy", busy, (cyc >= acc_lo) && (cyc <= ack_at));
      chk("i_rdata", i_rdata, e_irdata); chk("d_rdata", d_rdata, e_drdata);
      if (cyc >= idle_at && (ip || dp)) begin
        own_d  = dp;
        acc_lo = cyc + 1; acc_hi = cyc + AC; ack_at = cyc + AC + 1; idle_at = cyc + AC + 2;
        e_addr = dp ? d_addr : i_addr;
        e_rw   = dp ? d_rw : 1'b0;
        e_size = dp ? ((d_size == 2'b11) ? 2'b10 : d_size) : 2'b10;
        e_din  = d_wdata;
        a = e_addr[7:0];
        pend_rd = !e_rw;
        if (e_rw) begin
          ref_mem[a] = e_din[7:0];
          if (e_size != 2'b00) ref_mem[8'(a + 8'd1)] = e_din[15:8];
          if (e_size[1]) begin
            ref_mem[8'(a + 8'd2)] = e_din[23:16];
            ref_mem[8'(a + 8'd3)] = e_din[31:24];
          end
        end else begin
          pend_rdata = rd_bytes(ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)],
                                ref_mem[8'(a + 8'd3)], e_size);
        end
      end
      if (cyc == ack_at) begin
        if (own_d) dp = 0; else ip = 0;
      end
      cyc++;
      tick();
    end

    // Reset during the second access cycle of a store.
    i_req = 0; d_req = 0;
    repeat (AC + 3) tick();
    d_req = 1; d_rw = 1; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'h12345678;
    tick(); tick();
    #1;
    chk("r5_in_access", ram_enable, 1);
    reset = 1; d_req = 0;
    tick();
    reset = 0; #1;
    chk("r5_en", ram_enable, 0);     chk("r5_busy", busy, 0);
    chk("r5_d_ack", d_ack, 0);       chk("r5_i_ack", i_ack, 0);
    chk("r5_d_rdata", d_rdata, 0);   chk("r5_i_rdata", i_rdata, 0);
    chk("r5_addr", ram_addr, 0);     chk("r5_din", ram_din, 0);
    chk("r5_size", ram_size, 2'b10); chk("r5_rw", ram_rw, 0);
    tick(); #1;
    chk("r5_no_late_ack", d_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
